// File: rtl/seq_alu_pkg.sv
// Shared types and the wrap/saturate helper for the sequential ALU.
package alu_pkg;

    localparam int unsigned MAX_W = 32;
    localparam int unsigned P_W   = 64;

    typedef enum logic [1:0] {
        ALU_RA   = 2'b00,
        ALU_RB   = 2'b01,
        ALU_RADD = 2'b10,
        ALU_RMUL = 2'b11
    } alu_func_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Fit a wide signed value into n signed bits; returns {ovf, result} with result in the low n bits.
    function automatic logic [MAX_W:0] sat_trunc(input logic signed [P_W-1:0] p,
                                                 input int unsigned n,
                                                 input logic sat);
        logic signed [P_W-1:0] hi;
        logic signed [P_W-1:0] lo;
        logic signed [P_W-1:0] res;
        logic                  ovf;
        hi  = (64'sd1 <<< (n - 1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        ovf = (p > hi) || (p < lo);
        res = p;
        if (sat && ovf) begin
            res = (p > hi) ? hi : lo;
        end
        return {ovf, MAX_W'(res)};
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle between the datapath and the ALU.
interface seq_alu_if
    import alu_pkg::*;
#(
    parameter int unsigned N = 8
) ();
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    alu_func_t    func;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         ovf;

    modport master (
        output in_valid, a, b, func, out_ready,
        input  in_ready, out_valid, result, ovf
    );

    modport slave (
        input  in_valid, a, b, func, out_ready,
        output in_ready, out_valid, result, ovf
    );
endinterface

// File: rtl/seq_alu_mult.sv
// Unsigned N-cycle shift-add multiplier core; product_c is the value the next step will register.
module seq_mult #(
    parameter int unsigned N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load_i,
    input  logic           step_i,
    input  logic [N-1:0]   mcand_i,
    input  logic [N-1:0]   mplier_i,
    output logic           last_c,
    output logic [2*N-1:0] product_c
);
    localparam int unsigned PW = 2 * N;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  mcand_q, mcand_d;
    logic [PW-1:0] prod_q, prod_d, prod_step;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N:0]    acc_sum;

    // One iteration: conditional add into the upper half, then shift {acc, multiplier} right.
    always_comb begin
        acc_sum   = {1'b0, prod_q[PW-1:N]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_step = {acc_sum, prod_q[N-1:1]};
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        if (load_i) begin
            mcand_d = mcand_i;
            prod_d  = {{N{1'b0}}, mplier_i};
            cnt_d   = '0;
        end else if (step_i) begin
            prod_d = prod_step;
            cnt_d  = cnt_q + CW'(1);
        end
    end

    // Multiplier state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else begin
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
        end
    end

    assign last_c    = (cnt_q == CW'(N - 1));
    assign product_c = prod_step;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: pass-A, pass-B, add and shift-add fixed-point multiply behind a valid/ready handshake.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned N    = 8,
    parameter int unsigned FRAC = N - 1,
    parameter bit          SAT  = 1'b0
) (
    input logic       clk,
    input logic       nReset,
    seq_alu_if.slave  bus
);
    localparam int unsigned PW = 2 * N;

    state_t         state_q, state_d;
    logic [N-1:0]   result_q, result_d;
    logic           ovf_q, ovf_d;
    logic           sign_q, sign_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;

    logic           mul_load, mul_step, mul_last;
    logic [PW-1:0]  mul_prod, prod_signed;
    logic [N-1:0]   abs_a, abs_b;
    logic signed [P_W-1:0] add_ext, mul_ext;
    logic [MAX_W:0] add_sat, mul_sat;

    // Magnitudes for the unsigned core; -2^(N-1) maps to 2^(N-1) as an unsigned value.
    always_comb begin
        abs_a = bus.a[N-1] ? (-bus.a) : bus.a;
        abs_b = bus.b[N-1] ? (-bus.b) : bus.b;
    end

    // Sign-restore and scale the final product; widen the add so overflow is visible.
    always_comb begin
        add_ext     = P_W'(signed'(bus.a)) + P_W'(signed'(bus.b));
        prod_signed = sign_q ? (-mul_prod) : mul_prod;
        mul_ext     = P_W'(signed'(prod_signed)) >>> FRAC;
        add_sat     = sat_trunc(add_ext, N, SAT);
        mul_sat     = sat_trunc(mul_ext, N, SAT);
    end

    seq_mult #(.N(N)) u_mult (
        .clk       (clk),
        .rst_n     (nReset),
        .load_i    (mul_load),
        .step_i    (mul_step),
        .mcand_i   (abs_a),
        .mplier_i  (abs_b),
        .last_c    (mul_last),
        .product_c (mul_prod)
    );

    // Next-state, result capture and handshake outputs.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        sign_d   = sign_q;
        mul_load = 1'b0;
        mul_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = DONE;
                    case (bus.func)
                        ALU_RB: begin
                            result_d = bus.b;
                            ovf_d    = 1'b0;
                        end
                        ALU_RADD: begin
                            result_d = N'(add_sat);
                            ovf_d    = add_sat[MAX_W];
                        end
                        ALU_RMUL: begin
                            mul_load = 1'b1;
                            sign_d   = bus.a[N-1] ^ bus.b[N-1];
                            state_d  = MUL;
                        end
                        default: begin
                            result_d = bus.a;
                            ovf_d    = 1'b0;
                        end
                    endcase
                end
            end
            MUL: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    result_d = N'(mul_sat);
                    ovf_d    = mul_sat[MAX_W];
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q     <= IDLE;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            sign_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            sign_q      <= sign_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.ovf       = ovf_q;

endmodule
